bit_population_generator: RTL and testbench

- Inverse of the bit population counter: takes a requested ones-count and emits a WIDTH-bit word containing exactly that many set bits, at pseudo-random positions.
- Serves as the stimulus/pattern source feeding the population counter in block-level and system benches, and as a reusable sparse-mask generator.
- Iterative architecture: one bit placed per clock, free-running LFSR position source, single-request valid/ready input, pulsed-valid output.

---
 rtl/bit_population_generator.sv | 149 ++++++++++++++
 tb/tb_bit_population_generator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_population_generator.sv
`default_nettype none
// ============================================================================
// Module   : bit_population_generator
// Function : Emits a WIDTH-bit word with exactly N set bits at LFSR-chosen
//            positions, one bit placed per clock. Optional build macro:
//            BIT_POP_GEN_COMPLEMENT_EN (clear bits from all-ones when N > WIDTH/2)
// Revision : 1.0 - initial release
// ============================================================================
module bit_population_generator #(
    parameter int          WIDTH = 24,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [$clog2(WIDTH):0] data_i,
    input  logic                   data_val_i,
    output logic                   ready_o,
    output logic [WIDTH-1:0]       data_o,
    output logic                   data_val_o
);

    localparam int              c_k     = $clog2(WIDTH);
    localparam int              c_iw    = c_k + 1;
    localparam logic [15:0]     c_taps  = 16'hB400;
    localparam logic [c_iw-1:0] c_width = c_iw'(WIDTH);
`ifdef BIT_POP_GEN_COMPLEMENT_EN
    localparam logic [c_iw-1:0] c_half  = c_iw'(WIDTH / 2);
`endif

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_PLACE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [c_iw-1:0]   rem_q, rem_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              data_val_q, data_val_d;
    logic              ready_q, ready_d;
    logic              target_q, target_d;

    logic [c_iw-1:0]   w_n_clamp;
    logic [c_iw-1:0]   w_pos;
    logic [c_k-1:0]    w_sel;

    assign w_n_clamp = (data_i > c_width) ? c_width : data_i;

    // Folding out-of-range LFSR samples back into the word keeps every index reachable.
    always_comb begin
        w_pos = {1'b0, lfsr_q[c_k-1:0]};
        if (w_pos >= c_width) begin
            w_pos = w_pos - c_width;
        end
    end

    // Circular search upward from w_pos for the first bit not yet at the target value.
    always_comb begin
        logic            found;
        logic [c_iw-1:0] idx;
        found = 1'b0;
        idx   = '0;
        w_sel = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = w_pos + c_iw'(i);
            if (idx >= c_width) begin
                idx = idx - c_width;
            end
            if (!found && (word_q[idx[c_k-1:0]] != target_q)) begin
                found = 1'b1;
                w_sel = idx[c_k-1:0];
            end
        end
    end

    always_comb begin
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_taps : 16'h0000);
        state_d    = state_q;
        word_d     = word_q;
        rem_d      = rem_q;
        data_d     = data_q;
        data_val_d = 1'b0;
        ready_d    = ready_q;
        target_d   = target_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (data_val_i) begin
                    ready_d  = 1'b0;
                    state_d  = S_PLACE;
                    word_d   = '0;
                    rem_d    = w_n_clamp;
                    target_d = 1'b1;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
                    if (w_n_clamp > c_half) begin
                        word_d   = '1;
                        rem_d    = c_width - w_n_clamp;
                        target_d = 1'b0;
                    end
`endif
                end
            end
            S_PLACE: begin
                if (rem_q != '0) begin
                    word_d[w_sel] = target_q;
                    rem_d         = rem_q - 1'b1;
                end else begin
                    data_d     = word_q;
                    data_val_d = 1'b1;
                    ready_d    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            rem_q      <= '0;
            lfsr_q     <= SEED;
            data_q     <= '0;
            data_val_q <= 1'b0;
            ready_q    <= 1'b1;
            target_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            rem_q      <= rem_d;
            lfsr_q     <= lfsr_d;
            data_q     <= data_d;
            data_val_q <= data_val_d;
            ready_q    <= ready_d;
            target_q   <= target_d;
        end
    end

    assign ready_o    = ready_q;
    assign data_o     = data_q;
    assign data_val_o = data_val_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_population_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_population_generator
// Function : Randomised and directed bench for bit_population_generator at
//            WIDTH=24 and WIDTH=17 against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_population_generator;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [5:0]  a_data;
    logic        a_val;
    logic        a_ready;
    logic [23:0] a_out;
    logic        a_oval;

    logic [5:0]  b_data;
    logic        b_val;
    logic        b_ready;
    logic [16:0] b_out;
    logic        b_oval;

    int          n_total = 0;
    int          n_bad   = 0;
    int          which_g = 0;

    logic [15:0]  lfsr_a, lfsr_b;
    logic         v_ready, v_oval;
    logic [255:0] v_out;
    logic [255:0] last_exp;

    always #5 clk = ~clk;

    bit_population_generator #(.WIDTH(24), .SEED(SEED)) u_dut_a (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (a_data),
        .data_val_i (a_val),
        .ready_o    (a_ready),
        .data_o     (a_out),
        .data_val_o (a_oval)
    );

    bit_population_generator #(.WIDTH(17), .SEED(SEED)) u_dut_b (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .data_i     (b_data),
        .data_val_i (b_val),
        .ready_o    (b_ready),
        .data_o     (b_out),
        .data_val_o (b_oval)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running position source reference, one per instance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a <= SEED;
            lfsr_b <= SEED;
        end else begin
            lfsr_a <= lfsr_step(lfsr_a);
            lfsr_b <= lfsr_step(lfsr_b);
        end
    end

    always_comb begin
        v_out = '0;
        if (which_g == 0) begin
            v_ready     = a_ready;
            v_oval      = a_oval;
            v_out[23:0] = a_out;
        end else begin
            v_ready     = b_ready;
            v_oval      = b_oval;
            v_out[16:0] = b_out;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected word for a request of n accepted while the LFSR held l0.
    function automatic logic [255:0] model(input int w, input int n, input logic [15:0] l0,
                                           output int r, output int nc);
        logic [255:0] word;
        logic         tgt;
        logic [15:0]  l;
        int           kk;
        int           p;
        word = '0;
        tgt  = 1'b1;
        l    = l0;
        kk   = 0;
        while ((1 << kk) < w) kk++;
        nc = (n > w) ? w : n;
        r  = nc;
`ifdef BIT_POP_GEN_COMPLEMENT_EN
        if (nc > w / 2) begin
            for (int i = 0; i < w; i++) word[i] = 1'b1;
            tgt = 1'b0;
            r   = w - nc;
        end
`endif
        for (int k = 0; k < r; k++) begin
            l = lfsr_step(l);
            p = int'(l) % (1 << kk);
            if (p >= w) p = p - w;
            for (int i = 0; i < w; i++) begin
                int idx;
                idx = (p + i) % w;
                if (word[idx] != tgt) begin
                    word[idx] = tgt;
                    break;
                end
            end
        end
        return word;
    endfunction

    // Issues one request at the next edge and checks every cycle up to the pulse.
    task automatic req(input int which, input int n, input bit hold);
        int           w, r, nc;
        logic [15:0]  l0;
        logic [255:0] exp;
        which_g = which;
        if (which == 0) begin
            w = 24; a_data = 6'(n); a_val = 1'b1; l0 = lfsr_a;
        end else begin
            w = 17; b_data = 6'(n); b_val = 1'b1; l0 = lfsr_b;
        end
        exp = model(w, n, l0, r, nc);
        @(posedge clk); #1;
        if (!hold) begin
            a_val = 1'b0;
            b_val = 1'b0;
        end
        for (int k = 0; k <= r; k++) begin
            chk("busy_ready", 256'(v_ready), 256'(1'b0));
            chk("busy_val", 256'(v_oval), 256'(1'b0));
            @(posedge clk); #1;
        end
        chk("pulse", 256'(v_oval), 256'(1'b1));
        chk("ready_back", 256'(v_ready), 256'(1'b1));
        chk("word", v_out, exp);
        chk("popcount", 256'($countones(v_out)), 256'(nc));
        last_exp = exp;
    endtask

    task automatic idle_chk();
        a_val = 1'b0;
        b_val = 1'b0;
        @(posedge clk); #1;
        chk("pulse_width", 256'(v_oval), 256'(1'b0));
        chk("hold", v_out, last_exp);
        chk("idle_ready", 256'(v_ready), 256'(1'b1));
    endtask

    initial begin
        a_data = '0; a_val = 1'b0;
        b_data = '0; b_val = 1'b0;
        last_exp = '0;
        #12;
        chk("rst_ready_a", 256'(a_ready), 256'(1'b1));
        chk("rst_val_a", 256'(a_oval), 256'(1'b0));
        chk("rst_data_a", 256'(a_out), 256'(0));
        chk("rst_ready_b", 256'(b_ready), 256'(1'b1));
        chk("rst_data_b", 256'(b_out), 256'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        req(0, 0, 1'b0);  idle_chk();
        req(0, 5, 1'b1);  idle_chk();
        req(0, 24, 1'b0); idle_chk();
        chk("all_ones_24", v_out, 256'(24'hFFFFFF));
        req(0, 31, 1'b0); idle_chk();
        chk("all_ones_31", v_out, 256'(24'hFFFFFF));
        req(0, 20, 1'b0); idle_chk();

        // Abort a request of 10 after three placements.
        which_g = 0;
        a_data = 6'd10; a_val = 1'b1;
        @(posedge clk); #1;
        a_val = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_ready", 256'(a_ready), 256'(1'b1));
        chk("abort_val", 256'(a_oval), 256'(1'b0));
        chk("abort_data", 256'(a_out), 256'(0));
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_pulse", 256'(a_oval), 256'(1'b0));
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        req(0, 10, 1'b0); idle_chk();

        for (int i = 0; i < 1000; i++) req(0, int'($urandom_range(0, 63)), 1'b1);
        idle_chk();
        req(1, 0, 1'b0);  idle_chk();
        req(1, 17, 1'b0); idle_chk();
        chk("all_ones_17", v_out, 256'(17'h1FFFF));
        for (int i = 0; i < 1000; i++) req(1, int'($urandom_range(0, 63)), 1'b1);
        idle_chk();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
